// File: rtl/frame_sequencer.sv
// Per-frame erase -> move -> redraw sequencer for the platform drawer.
// Divides clk into frames and emits draw/enable/erase/wr_gate strobes.
module frame_sequencer #(
    parameter int CLK_PER_FRAME = 833333,
    parameter int DRAW_CYCLES   = 24,
    parameter int MOVE_DIV      = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pause,
    input  logic       left_btn,
    input  logic       right_btn,
    output logic       left,
    output logic       right,
    output logic       enable,
    output logic       draw,
    output logic       erase,
    output logic       wr_gate,
    output logic       frame_tick,
    output logic [7:0] frame_count,
    output logic       overrun
);

    localparam int TW = $clog2(CLK_PER_FRAME);
    localparam int CW = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
    localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [TW-1:0] T_MAX  = TW'(CLK_PER_FRAME - 1);
    localparam logic [CW-1:0] C_LOAD = CW'(DRAW_CYCLES - 1);
    localparam logic [MW-1:0] M_MAX  = MW'(MOVE_DIV - 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_ERASE_START,
        S_ERASE,
        S_MOVE,
        S_DRAW_START,
        S_DRAW
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer;
    logic [CW-1:0]   cnt, cnt_n;
    logic [MW-1:0]   move_cnt, move_cnt_n;
    logic            left_n, right_n;
    logic            done;

    assign frame_tick = (timer == T_MAX);

    // Frame timer free-runs regardless of the sequencer state.
    always_ff @(posedge clk) begin
        if (!resetn)
            timer <= '0;
        else if (frame_tick)
            timer <= '0;
        else
            timer <= timer + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_WAIT;
            cnt         <= '0;
            move_cnt    <= '0;
            left        <= 1'b0;
            right       <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            move_cnt <= move_cnt_n;
            left     <= left_n;
            right    <= right_n;
            if (done)
                frame_count <= frame_count + 8'd1;
            // A tick arriving mid-sequence is dropped, never queued.
            if (frame_tick && state != S_WAIT)
                overrun <= 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        move_cnt_n = move_cnt;
        left_n     = left;
        right_n    = right;
        draw       = 1'b0;
        erase      = 1'b0;
        wr_gate    = 1'b0;
        enable     = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (frame_tick && !pause) begin
                    state_n = S_ERASE_START;
                    left_n  = left_btn & ~right_btn;
                    right_n = right_btn & ~left_btn;
                    cnt_n   = C_LOAD;
                end
            end
            S_ERASE_START: begin
                draw    = 1'b1;
                erase   = 1'b1;
                wr_gate = 1'b1;
                state_n = S_ERASE;
            end
            S_ERASE: begin
                erase   = 1'b1;
                wr_gate = 1'b1;
                if (cnt == '0)
                    state_n = S_MOVE;
                else
                    cnt_n = cnt - CW'(1);
            end
            S_MOVE: begin
                enable     = (move_cnt == '0);
                move_cnt_n = (move_cnt == M_MAX) ? '0 : move_cnt + MW'(1);
                cnt_n      = C_LOAD;
                state_n    = S_DRAW_START;
            end
            S_DRAW_START: begin
                draw    = 1'b1;
                wr_gate = 1'b1;
                state_n = S_DRAW;
            end
            S_DRAW: begin
                wr_gate = 1'b1;
                if (cnt == '0) begin
                    state_n = S_WAIT;
                    done    = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: three parameter sets checked every cycle
// against a position-in-sequence reference model.
module tb_frame_sequencer;

    localparam int N = 3;
    localparam int D = 4;
    localparam int CPF [N] = '{100, 100, 10};
    localparam int MD  [N] = '{1, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn = 1'b0;
    logic pause = 1'b0;
    logic left_btn = 1'b0;
    logic right_btn = 1'b0;

    logic [N-1:0] lf, rt, en, dr, er, wg, ft, ov;
    logic [7:0]   fc [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        frame_sequencer #(
            .CLK_PER_FRAME(CPF[g]),
            .DRAW_CYCLES(D),
            .MOVE_DIV(MD[g])
        ) u_dut (
            .clk(clk),
            .resetn(resetn),
            .pause(pause),
            .left_btn(left_btn),
            .right_btn(right_btn),
            .left(lf[g]),
            .right(rt[g]),
            .enable(en[g]),
            .draw(dr[g]),
            .erase(er[g]),
            .wr_gate(wg[g]),
            .frame_tick(ft[g]),
            .frame_count(fc[g]),
            .overrun(ov[g])
        );
    end

    // Model: m_pos is cycles since the accepted tick edge, -1 when idle.
    int m_timer [N];
    int m_pos   [N];
    int m_seqs  [N];
    int m_fc    [N];
    bit m_l     [N];
    bit m_r     [N];
    bit m_ov    [N];
    int en_cnt  [N];
    int dr_cnt  [N];
    int since;
    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_flags(input int i);
        int  p;
        bit  act, e_en, e_dr, e_er, e_wg, e_ft;
        p    = m_pos[i];
        act  = (p >= 0);
        e_en = (p == D + 1) && (((m_seqs[i] - 1) % MD[i]) == 0);
        e_dr = (p == 0) || (p == D + 2);
        e_er = act && (p <= D);
        e_wg = act && (p != D + 1);
        e_ft = (m_timer[i] == CPF[i] - 1);
        return {m_l[i], m_r[i], e_en, e_dr, e_er, e_wg, e_ft, m_ov[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_timer[i] = 0;
            m_pos[i]   = -1;
            m_seqs[i]  = 0;
            m_fc[i]    = 0;
            m_l[i]     = 0;
            m_r[i]     = 0;
            m_ov[i]    = 0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("flags%0d", i),
                  {lf[i], rt[i], en[i], dr[i], er[i], wg[i], ft[i], ov[i]},
                  exp_flags(i));
            check($sformatf("fcount%0d", i), fc[i], m_fc[i]);
            en_cnt[i] += int'(en[i]);
            dr_cnt[i] += int'(dr[i]);
        end
    endtask

    task automatic advance();
        bit tk;
        if (!resetn) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                tk = (m_timer[i] == CPF[i] - 1);
                if (tk && m_pos[i] >= 0)
                    m_ov[i] = 1;
                if (m_pos[i] >= 0) begin
                    if (m_pos[i] == 2 * D + 2) begin
                        m_pos[i] = -1;
                        m_fc[i]  = (m_fc[i] + 1) % 256;
                    end else begin
                        m_pos[i]++;
                    end
                end else if (tk && !pause) begin
                    m_pos[i] = 0;
                    m_l[i]   = left_btn & ~right_btn;
                    m_r[i]   = right_btn & ~left_btn;
                    m_seqs[i]++;
                end
                m_timer[i] = tk ? 0 : m_timer[i] + 1;
            end
        end
        @(posedge clk);
        since = resetn ? since + 1 : 0;
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            sample();
            resetn = 1'b0;
            advance();
        end
        for (int i = 0; i < N; i++) begin
            en_cnt[i] = 0;
            dr_cnt[i] = 0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        since = 0;
        model_reset();
        @(posedge clk);
        do_reset(3);

        // Timing, button latching and MOVE_DIV over four frames.
        for (int c = 0; c < 450; c++) begin
            sample();
            if (c == 0)
                check("rst_state", {lf[0], rt[0], en[0], dr[0], er[0], wg[0], ov[0]}, 0);
            if (c == 99)  check("tick99", ft[0], 1);
            if (c == 100) check("draw100", {dr[0], er[0], wg[0]}, 3'b111);
            if (c == 104) check("erase104", {dr[0], er[0], wg[0]}, 3'b011);
            if (c == 105) check("en105", {en[0], dr[0], er[0], wg[0]}, 4'b1000);
            if (c == 105) check("lr105", {lf[0], rt[0]}, 2'b10);
            if (c == 106) check("draw106", {dr[0], er[0], wg[0]}, 3'b101);
            if (c == 110) check("wg110", wg[0], 1);
            if (c == 111) check("fc111", {wg[0], fc[0]}, 9'd1);
            if (c == 205) check("both205", {lf[0], rt[0], en[0]}, 3'b001);
            if (c == 25)  check("ovr25", ov[2], 1);
            if (c == 440) check("ovr440", {ov[2], ov[0]}, 2'b10);
            resetn    = 1'b1;
            pause     = 1'b0;
            left_btn  = 1'b1;
            right_btn = (c >= 150);
            advance();
        end
        check("en_frames_div1", en_cnt[0], 4);
        check("en_frames_div2", en_cnt[1], 2);
        check("draws_div2", dr_cnt[1], 8);

        // Pause held across one tick, then normal operation.
        do_reset(2);
        for (int c = 0; c < 250; c++) begin
            sample();
            if (c == 120) check("pause_fc", fc[0], 0);
            if (c == 150) check("pause_draws", dr_cnt[0], 0);
            if (c == 212) check("unpause_fc", fc[0], 1);
            resetn    = 1'b1;
            pause     = (c >= 90 && c <= 110);
            left_btn  = 1'b0;
            right_btn = 1'b1;
            advance();
        end

        // Reset asserted in the middle of the erase pass.
        do_reset(2);
        for (int c = 0; c <= 102; c++) begin
            sample();
            if (c == 102) check("mid_erase", er[0], 1);
            resetn = (c != 102);
            advance();
        end
        for (int c = 0; c < 120; c++) begin
            sample();
            if (c == 0) check("post_rst", {en[0], dr[0], er[0], wg[0], fc[0]}, 0);
            if (c == 98) check("no_tick98", ft[0], 0);
            if (c == 99) check("tick_after_rst", ft[0], 1);
            resetn = 1'b1;
            advance();
        end

        // Randomized traffic with occasional pause toggles and resets.
        for (int c = 0; c < 4000; c++) begin
            sample();
            resetn    = ($urandom_range(0, 699) != 0);
            left_btn  = $urandom_range(0, 1) == 1;
            right_btn = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 39) == 0)
                pause = ~pause;
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
